instr_load_ctrl: RTL and testbench

Sequencer for the processor's input mode. It captures 8-bit instruction bytes from the board switches, one byte per toggle of the input button, and packs them into the 64-bit instruction image. When the check button is pressed, it scans the image for RAW hazards one instruction per cycle and publishes a hazard bitmap. It then releases the 5-stage pipeline by asserting run_en.

---
 rtl/instr_load_ctrl.sv | 151 +++++++++++++++
 tb/tb_instr_load_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_load_ctrl.sv
// Input-mode sequencer: packs switch bytes into the instruction image on each load-button
// toggle, scans the image for RAW hazards on a check press, then releases the pipeline.
module instr_load_ctrl #(
   parameter int DEPTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [7:0]               input_val,
   input  logic                     but_inp,
   input  logic                     but_check,
   output logic [8*DEPTH-1:0]       instr_mem_bits,
   output logic [DEPTH-1:0]         hazard_bits,
   output logic [$clog2(DEPTH):0]   load_count,
   output logic                     overflow,
   output logic                     busy,
   output logic                     run_en,
   output logic [1:0]               state
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      SCAN = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t                 cur_state;
   state_t                 next_state;
   logic [SYNC_STAGES-1:0] inp_sync;
   logic [SYNC_STAGES-1:0] chk_sync;
   logic                   inp_prev;
   logic                   chk_prev;
   logic                   tog_ev;
   logic                   chk_ev;
   logic [IW-1:0]          scan_idx;
   logic [7:0]             cur_b;
   logic [7:0]             pm1_b;
   logic [7:0]             pm2_b;
   logic                   haz_now;

   // Older instruction j conflicts with current instruction i when both are real ops and
   // j writes a register that i reads or writes.
   function automatic logic conflicts(input logic [7:0] older, input logic [7:0] cur);
      return (older[7:4] != 4'd0) && (cur[7:4] != 4'd0) &&
             ((older[3:2] == cur[1:0]) || (older[3:2] == cur[3:2]));
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inp_sync <= '0;
         chk_sync <= '0;
         inp_prev <= 1'b0;
         chk_prev <= 1'b0;
      end else begin
         inp_sync[0] <= but_inp;
         chk_sync[0] <= but_check;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            inp_sync[k] <= inp_sync[k-1];
            chk_sync[k] <= chk_sync[k-1];
         end
         inp_prev <= inp_sync[SYNC_STAGES-1];
         chk_prev <= chk_sync[SYNC_STAGES-1];
      end
   end

   assign tog_ev = inp_sync[SYNC_STAGES-1] ^ inp_prev;
   assign chk_ev = chk_sync[SYNC_STAGES-1] & ~chk_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state <= LOAD;
      end else begin
         cur_state <= next_state;
      end
   end

   always_comb begin
      next_state = LOAD;
      case (cur_state)
         LOAD:    next_state = chk_ev ? SCAN : LOAD;
         SCAN:    next_state = (scan_idx == IW'(DEPTH-1)) ? RUN : SCAN;
         RUN:     next_state = chk_ev ? LOAD : RUN;
         default: next_state = LOAD;
      endcase
   end

   // Neighbours outside the image read as NOPs, so instruction 0 can never be flagged.
   always_comb begin
      int i_cur;
      i_cur = int'(scan_idx);
      cur_b = instr_mem_bits[8*i_cur +: 8];
      pm1_b = 8'd0;
      pm2_b = 8'd0;
      if (i_cur >= 1) begin
         pm1_b = instr_mem_bits[8*(i_cur-1) +: 8];
      end
      if (i_cur >= 2) begin
         pm2_b = instr_mem_bits[8*(i_cur-2) +: 8];
      end
      haz_now = conflicts(pm1_b, cur_b) | conflicts(pm2_b, cur_b);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_mem_bits <= '0;
         hazard_bits    <= '0;
         load_count     <= '0;
         overflow       <= 1'b0;
         scan_idx       <= '0;
      end else begin
         case (cur_state)
            LOAD: begin
               if (tog_ev) begin
                  if (load_count < CW'(DEPTH)) begin
                     instr_mem_bits[8*load_count +: 8] <= input_val;
                     load_count <= load_count + 1'b1;
                  end else begin
                     overflow <= 1'b1;
                  end
               end
               if (chk_ev) begin
                  scan_idx    <= '0;
                  hazard_bits <= '0;
               end
            end
            SCAN: begin
               hazard_bits[scan_idx] <= haz_now;
               scan_idx <= scan_idx + 1'b1;
            end
            RUN: begin
               if (chk_ev) begin
                  instr_mem_bits <= '0;
                  hazard_bits    <= '0;
                  load_count     <= '0;
                  overflow       <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy   = (cur_state == SCAN);
   assign run_en = (cur_state == RUN);
   assign state  = cur_state;

endmodule

// File: tb/tb_instr_load_ctrl.sv
// Scoreboard bench for instr_load_ctrl: each scan request queues its expected image,
// hazard map and latency; a monitor checks them when run_en rises.
module tb_instr_load_ctrl;

   localparam int DEPTH = 8;
   localparam int SYNC  = 2;
   localparam int LAT   = SYNC + 1 + DEPTH;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  input_val = 8'd0;
   logic        but_inp = 1'b0;
   logic        but_check = 1'b0;
   logic [63:0] instr_mem_bits;
   logic [7:0]  hazard_bits;
   logic [3:0]  load_count;
   logic        overflow;
   logic        busy;
   logic        run_en;
   logic [1:0]  state;

   typedef struct {
      logic [63:0] img;
      logic [7:0]  haz;
      logic [3:0]  cnt;
      logic        ovf;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   logic prev_run = 1'b0;

   instr_load_ctrl #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst_n(rst_n), .input_val(input_val), .but_inp(but_inp),
      .but_check(but_check), .instr_mem_bits(instr_mem_bits), .hazard_bits(hazard_bits),
      .load_count(load_count), .overflow(overflow), .busy(busy), .run_en(run_en),
      .state(state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: a rising run_en marks a finished scan; compare against the oldest request.
   always @(negedge clk) begin
      if (rst_n && run_en && !prev_run) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_run actual=1 required=0");
         end else begin
            mon_e = sb.pop_front();
            checkOutput("run_image", instr_mem_bits, mon_e.img);
            checkOutput("run_hazard", 64'(hazard_bits), 64'(mon_e.haz));
            checkOutput("run_count", 64'(load_count), 64'(mon_e.cnt));
            checkOutput("run_overflow", 64'(overflow), 64'(mon_e.ovf));
            checkOutput("run_latency", 64'(cyc), 64'(mon_e.cyc));
         end
      end
      prev_run <= run_en;
   end

   task automatic applyStimulus(input logic [7:0] val, input logic tog, input logic chk,
                                input int hold);
      @(negedge clk);
      input_val = val;
      if (tog) but_inp = ~but_inp;
      but_check = chk;
      repeat (hold) @(negedge clk);
   endtask

   task automatic loadByte(input logic [7:0] val);
      applyStimulus(val, 1'b1, but_check, 4);
   endtask

   // Raises the check pin (optionally with a simultaneous load toggle) and queues the result.
   task automatic startScan(input logic tog, input logic [7:0] val, input logic push,
                            input logic [63:0] img, input logic [7:0] haz,
                            input logic [3:0] cnt, input logic ovf);
      @(negedge clk);
      if (push) sb.push_back('{img, haz, cnt, ovf, cyc + LAT});
      input_val = val;
      if (tog) but_inp = ~but_inp;
      but_check = 1'b1;
   endtask

   task automatic finishScan();
      repeat (LAT + 3) @(negedge clk);
      but_check = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_state"}, 64'(state), 64'd0);
      checkOutput({tag, "_image"}, instr_mem_bits, 64'd0);
      checkOutput({tag, "_hazard"}, 64'(hazard_bits), 64'd0);
      checkOutput({tag, "_count"}, 64'(load_count), 64'd0);
      checkOutput({tag, "_overflow"}, 64'(overflow), 64'd0);
      checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
      checkOutput({tag, "_run_en"}, 64'(run_en), 64'd0);
   endtask

   task automatic returnToLoad(input string tag);
      applyStimulus(input_val, 1'b0, 1'b0, 3);
      applyStimulus(input_val, 1'b0, 1'b1, 5);
      checkReset(tag);
      applyStimulus(input_val, 1'b0, 1'b0, 3);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (2) @(negedge clk);
      checkReset("reset");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Four real instructions followed by four explicit NOP bytes.
      loadByte(8'hCA); loadByte(8'hDC); loadByte(8'h59); loadByte(8'h9E);
      for (int k = 0; k < 4; k++) loadByte(8'h00);
      startScan(1'b0, 8'h00, 1'b1, 64'h0000_0000_9E59_DCCA, 8'h0C, 4'd8, 1'b0);
      repeat (5) @(negedge clk);
      checkOutput("scan_busy", 64'(busy), 64'd1);
      checkOutput("scan_run_en", 64'(run_en), 64'd0);
      repeat (LAT) @(negedge clk);
      checkOutput("hold_run_en", 64'(run_en), 64'd1);
      but_check = 1'b0;
      repeat (4) @(negedge clk);
      returnToLoad("run_clear1");

      // Partial image: unloaded bytes remain NOPs.
      loadByte(8'h15); loadByte(8'h44);
      startScan(1'b0, 8'h00, 1'b1, 64'h0000_0000_0000_4415, 8'h02, 4'd2, 1'b0);
      finishScan();
      returnToLoad("run_clear2");

      // Ninth byte overflows and is discarded.
      for (int k = 0; k < 9; k++) loadByte(8'h11 + 8'(k));
      checkOutput("ovf_flag", 64'(overflow), 64'd1);
      checkOutput("ovf_count", 64'(load_count), 64'd8);
      startScan(1'b0, 8'h00, 1'b1, 64'h1817_1615_1413_1211, 8'h7E, 4'd8, 1'b1);
      finishScan();
      returnToLoad("run_clear3");

      // Fourth byte arrives together with the check press and must be scanned.
      loadByte(8'h15); loadByte(8'h2A); loadByte(8'h3F);
      startScan(1'b1, 8'h4B, 1'b1, 64'h0000_0000_4B3F_2A15, 8'h08, 4'd4, 1'b0);
      finishScan();
      returnToLoad("run_clear4");

      // Button activity during the scan must be ignored.
      loadByte(8'h21); loadByte(8'h22);
      startScan(1'b0, 8'h00, 1'b1, 64'h0000_0000_0000_2221, 8'h02, 4'd2, 1'b0);
      repeat (3) @(negedge clk);
      but_check = 1'b0;
      @(negedge clk);
      input_val = 8'h77;
      but_inp = ~but_inp;
      checkOutput("ignore_busy", 64'(busy), 64'd1);
      @(negedge clk);
      but_check = 1'b1;
      @(negedge clk);
      but_inp = ~but_inp;
      repeat (8) @(negedge clk);
      checkOutput("ignore_count", 64'(load_count), 64'd2);
      checkOutput("ignore_image", instr_mem_bits, 64'h0000_0000_0000_2221);
      returnToLoad("run_clear5");

      // Asynchronous reset while scan index is 3.
      loadByte(8'h33); loadByte(8'h34); loadByte(8'h35); loadByte(8'h36);
      startScan(1'b0, 8'h00, 1'b0, 64'd0, 8'd0, 4'd0, 1'b0);
      repeat (6) @(negedge clk);
      checkOutput("pre_reset_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      but_inp = 1'b0;
      but_check = 1'b0;
      #1;
      checkReset("async_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      loadByte(8'h5A);
      checkOutput("reload_count", 64'(load_count), 64'd1);
      checkOutput("reload_image", instr_mem_bits, 64'h0000_0000_0000_005A);
      startScan(1'b0, 8'h00, 1'b1, 64'h0000_0000_0000_005A, 8'h00, 4'd1, 1'b0);
      finishScan();

      repeat (5) @(negedge clk);
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("[TB] FAIL pending_scans actual=%0d required=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
